// File: rtl/vga_pkg.sv
// Shared VGA timing types: line descriptor, region encoding, 640x480@60 defaults.
// Pure declarations, no logic, so no latency applies.
// No flow control; values are consumed combinationally by the timing blocks.
package vga_pkg;

  localparam int TIMING_WIDTH = 12;

  typedef struct packed {
    logic [TIMING_WIDTH-1:0] visible_area;
    logic [TIMING_WIDTH-1:0] front_porch;
    logic [TIMING_WIDTH-1:0] sync_pulse;
    logic [TIMING_WIDTH-1:0] back_porch;
    logic                    polarity;
  } line_t;

  typedef enum logic [1:0] {
    REG_VISIBLE = 2'd0,
    REG_FRONT   = 2'd1,
    REG_SYNC    = 2'd2,
    REG_BACK    = 2'd3
  } region_t;

  // 640x480@60: 800 clocks per line, 525 lines per frame, negative syncs.
  localparam line_t H_640X480 = '{
    visible_area: TIMING_WIDTH'(640),
    front_porch:  TIMING_WIDTH'(16),
    sync_pulse:   TIMING_WIDTH'(96),
    back_porch:   TIMING_WIDTH'(48),
    polarity:     1'b0
  };

  localparam line_t V_640X480 = '{
    visible_area: TIMING_WIDTH'(480),
    front_porch:  TIMING_WIDTH'(10),
    sync_pulse:   TIMING_WIDTH'(2),
    back_porch:   TIMING_WIDTH'(33),
    polarity:     1'b0
  };

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with region decode and end-of-axis wrap strobe.
// Count updates one clock after i_step; region and wrap are combinational from the count.
// No backpressure; i_step is the only advance control, the count holds while it is low.
import vga_pkg::*;

module vga_axis_counter #(
  parameter int CNT_WIDTH = TIMING_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_step,
  input  line_t                i_line,
  output logic [CNT_WIDTH-1:0] o_count,
  output region_t              o_region,
  output logic                 o_wrap
);

  // Two guard bits so the sum of four full-width fields cannot overflow.
  localparam int SW = CNT_WIDTH + 2;

  logic [CNT_WIDTH-1:0] r_count;
  logic [SW-1:0]        w_b_front;
  logic [SW-1:0]        w_b_sync;
  logic [SW-1:0]        w_b_back;
  logic [SW-1:0]        w_total;
  logic [SW-1:0]        w_last;
  logic [SW-1:0]        w_cnt_ext;
  logic                 w_at_end;
  logic                 w_unused_pol;

  // Region boundaries are cumulative sums, so a zero-length field simply vanishes.
  assign w_b_front = SW'(i_line.visible_area);
  assign w_b_sync  = w_b_front + SW'(i_line.front_porch);
  assign w_b_back  = w_b_sync + SW'(i_line.sync_pulse);
  assign w_total   = w_b_back + SW'(i_line.back_porch);

  // A zero total behaves as a one-position axis: the counter parks at 0.
  assign w_last    = (w_total == '0) ? '0 : (w_total - SW'(1));
  assign w_cnt_ext = SW'(r_count);

  // >= rather than == so a descriptor that shrinks below the current count still wraps.
  assign w_at_end  = (w_cnt_ext >= w_last);
  assign o_wrap    = i_step & w_at_end;
  assign o_count   = r_count;

  // Polarity belongs to the sync output stage, not to counting.
  assign w_unused_pol = i_line.polarity;

  // Map the current count onto VISIBLE / FRONT / SYNC / BACK.
  always_comb begin
    o_region = REG_BACK;
    if (w_cnt_ext < w_b_front) begin
      o_region = REG_VISIBLE;
    end else if (w_cnt_ext < w_b_sync) begin
      o_region = REG_FRONT;
    end else if (w_cnt_ext < w_b_back) begin
      o_region = REG_SYNC;
    end
  end

  // Advance on step, returning to 0 at the end of the axis.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (i_step) begin
      r_count <= w_at_end ? '0 : (r_count + CNT_WIDTH'(1));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: coordinates, data-enable, polarity-corrected syncs, line/frame pulses.
// Outputs are registered decodes of the pre-edge counters (1 clock latency).
// enable_i low freezes counters and outputs; optional VGA_TIMING_SHADOW_EN defers mode changes to frame start.
import vga_pkg::*;

module vga_timing_gen #(
  parameter int CNT_WIDTH = TIMING_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  line_t                h_line_i,
  input  line_t                v_line_i,
  output logic [CNT_WIDTH-1:0] x_o,
  output logic [CNT_WIDTH-1:0] y_o,
  output logic                 de_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 line_start_o,
  output logic                 frame_start_o
);

  line_t                w_h_line;
  line_t                w_v_line;
  logic [CNT_WIDTH-1:0] w_h_cnt;
  logic [CNT_WIDTH-1:0] w_v_cnt;
  region_t              w_h_reg;
  region_t              w_v_reg;
  logic                 w_h_wrap;
  logic                 w_v_wrap;
  logic                 w_h_vis;
  logic                 w_v_vis;
  logic                 w_de;
  logic                 w_h_sync;
  logic                 w_v_sync;
  logic                 w_h_first;

  logic [CNT_WIDTH-1:0] r_x;
  logic [CNT_WIDTH-1:0] r_y;
  logic                 r_de;
  logic                 r_hsync;
  logic                 r_vsync;
  logic                 r_line_start;
  logic                 r_frame_start;

`ifdef VGA_TIMING_SHADOW_EN
  line_t r_h_line;
  line_t r_v_line;

  // Latch the incoming mode on the final pixel of a frame so a change lands exactly on (0,0).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_h_line <= H_640X480;
      r_v_line <= V_640X480;
    end else if (w_v_wrap) begin
      r_h_line <= h_line_i;
      r_v_line <= v_line_i;
    end
  end

  assign w_h_line = r_h_line;
  assign w_v_line = r_v_line;
`else
  logic w_unused_vwrap;

  // Live decode: a mid-frame change can distort one line/frame until the wrap rule catches up.
  assign w_h_line       = h_line_i;
  assign w_v_line       = v_line_i;
  assign w_unused_vwrap = w_v_wrap;
`endif

  vga_axis_counter #(.CNT_WIDTH(CNT_WIDTH)) u_h_axis (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_step   (enable_i),
    .i_line   (w_h_line),
    .o_count  (w_h_cnt),
    .o_region (w_h_reg),
    .o_wrap   (w_h_wrap)
  );

  // Vertical axis advances once per completed line, so vsync only moves at h_cnt=0.
  vga_axis_counter #(.CNT_WIDTH(CNT_WIDTH)) u_v_axis (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_step   (w_h_wrap),
    .i_line   (w_v_line),
    .o_count  (w_v_cnt),
    .o_region (w_v_reg),
    .o_wrap   (w_v_wrap)
  );

  assign w_h_vis   = (w_h_reg == REG_VISIBLE);
  assign w_v_vis   = (w_v_reg == REG_VISIBLE);
  assign w_de      = w_h_vis & w_v_vis;
  assign w_h_sync  = (w_h_reg == REG_SYNC);
  assign w_v_sync  = (w_v_reg == REG_SYNC);
  assign w_h_first = (w_h_cnt == '0);

  // Register the decode of the pre-edge counters; coordinates are zeroed in blanking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x           <= '0;
      r_y           <= '0;
      r_de          <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (enable_i) begin
      r_x           <= w_de ? w_h_cnt : '0;
      r_y           <= w_v_vis ? w_v_cnt : '0;
      r_de          <= w_de;
      r_hsync       <= w_h_line.polarity ? w_h_sync : ~w_h_sync;
      r_vsync       <= w_v_line.polarity ? w_v_sync : ~w_v_sync;
      r_line_start  <= w_de & w_h_first;
      r_frame_start <= w_de & w_h_first & (w_v_cnt == '0);
    end
  end

  assign x_o           = r_x;
  assign y_o           = r_y;
  assign de_o          = r_de;
  assign hsync_o       = r_hsync;
  assign vsync_o       = r_vsync;
  assign line_start_o  = r_line_start;
  assign frame_start_o = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing: pixel coordinates, data-enable, sync pulses and frame/line markers.
- Sits directly upstream of image_gen. Its x_o, y_o and de_o drive image_gen's x_i, y_i and de_i.
- Its h_line_i and v_line_i are the same line_t descriptors fed to image_gen.
- hsync_o and vsync_o go to the output pins, aligned with image_gen output by the pixel-output stage.

Parameters:
- CNT_WIDTH, default TIMING_WIDTH (from vga_pkg): width of the internal h/v counters and of the x_o/y_o outputs.

Ports:
- clk_i  in  1  pixel clock; the block uses this single clock only
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  advance timing; when low, everything holds
- h_line_i  in  line_t  horizontal timing: visible_area, front_porch, sync_pulse, back_porch, polarity
- v_line_i  in  line_t  vertical timing, same fields
- x_o  out  CNT_WIDTH  horizontal pixel coordinate
- y_o  out  CNT_WIDTH  vertical line coordinate
- de_o  out  1  pixel is in the visible area
- hsync_o  out  1  horizontal sync, polarity applied
- vsync_o  out  1  vertical sync, polarity applied
- line_start_o  out  1  one-cycle pulse on the first pixel of each visible line
- frame_start_o  out  1  one-cycle pulse on pixel (0,0)

Behaviour:
- Reset: all outputs 0, counters h_cnt = v_cnt = 0, shadow registers loaded with the vga_pkg 640x480@60 constants.
- Reset clears state immediately, including mid-line; timing restarts at (0,0) after release.
- Region order on each axis: VISIBLE, FRONT_PORCH, SYNC, BACK_PORCH.
- Axis total = visible + front + sync + back, computed in CNT_WIDTH+2 bits.
- Per enabled clock:
  - h_cnt increments.
  - h_cnt wraps to 0 when h_cnt >= H_TOTAL-1. The >= comparison recovers if the total shrinks below the current count.
  - v_cnt increments only on an h wrap, and wraps to 0 when v_cnt >= V_TOTAL-1.
- Outputs are registered decodes of the counter value present before the edge (latency 1 clock). The first enabled edge after reset therefore gives x_o=0, y_o=0, de_o=1, frame_start_o=1, line_start_o=1.
- de_o = (h region VISIBLE) and (v region VISIBLE).
- x_o = h_cnt when de_o is 1, otherwise 0. y_o = v_cnt when the v region is VISIBLE, otherwise 0. image_gen's end-of-frame compare therefore cannot fire in blanking.
- Sync pulses:
  - Raw hsync is active while the h region is SYNC; raw vsync while the v region is SYNC. vsync changes only at h_cnt=0.
  - Output = raw when polarity=1, ~raw when polarity=0.
- line_start_o = de at h_cnt=0. frame_start_o = line_start at v_cnt=0.
- enable_i low: counters and all outputs hold; pulses do not repeat when enable returns.
- Degenerate descriptors:
  - Any field = 0 means that region is skipped.
  - visible_area = 0 means de_o never asserts.
  - Total = 0 is treated as 1 (counter stays at 0).

Optional Feature:
- Macro: VGA_TIMING_SHADOW_EN.
- Defined: h_line_i and v_line_i are captured into shadow registers on the enabled clock where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. All decoding uses the shadow copies, so a mode change takes effect exactly at the next frame start.
- Not defined: the inputs are decoded live every cycle and no shadow registers exist. A mid-frame change may produce one malformed line or frame, which the >= wrap rule recovers from.

Decomposition:
- vga_pkg holds: line_t, TIMING_WIDTH, the 640x480@60 default constants (H 640/16/96/48, V 480/10/2/33, both polarity 0), and the region enum (REG_VISIBLE, REG_FRONT, REG_SYNC, REG_BACK).
- Sub-module vga_axis_counter, instantiated twice (h, v):
  - Inputs: step, line_t.
  - Outputs: count, region, wrap.
- The v instance steps on the h instance's wrap output.

Test Plan:
- Reset release, 640x480 inputs, enable=1:
  - Frame period is 420000 clocks.
  - frame_start_o pulses once per frame.
  - 480 line_start_o pulses per frame.
  - de_o high for exactly 307200 clocks per frame.
- Horizontal timing, 640x480: hsync_o low for 96 clocks, beginning 16 clocks after the last de_o of each line. Line period is 800 clocks.
- Vertical timing, 640x480: vsync_o low for exactly 2 lines (1600 clocks), starting at h position 0 of line 490.
- Polarity: set both polarity fields to 1 → hsync_o and vsync_o are inverted relative to the previous run, with identical timing.
- Enable and reset interruptions:
  - Toggle enable_i low for 37 clocks mid-line → all outputs frozen for those 37 clocks; the line completes with correct total length.
  - Assert rst_i mid-frame → all outputs 0 immediately, without waiting for a clock edge.
- Mode change with VGA_TIMING_SHADOW_EN defined: switch to 800x600 (H 800/40/128/88, V 600/1/4/23) at line 100 → current frame stays 420000 clocks, next frame is 1056×628 = 663168 clocks. Without the macro: recovery to the 663168-clock frame within two frames.
